// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and word-completion rule for the 1:16 deserializer.
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_e;

  // A word closes on an explicit last, or when auto mode writes the top bit.
  function automatic logic isCompletion(input logic             lastBit,
                                        input logic             selMode,
                                        input logic [SEL_W-1:0] ptr);
    return lastBit || (!selMode && (ptr == SEL_W'(WIDTH - 1)));
  endfunction

endpackage

// File: rtl/dec_4to16.sv
// 4-bit index to one-hot write enable; drives both the shadow write and the mask update.
module dec_4to16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] idx_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/demux_1to16_deser.sv
// Serial-to-parallel 1:16 demultiplexer: collects one bit per beat into a shadow word
// and presents the completed word and its written-bit mask on a valid/ready port.
module demux_1to16_deser
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sel_mode,
  input  logic [SEL_W-1:0] s,
  input  logic             last,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_mask,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [SEL_W-1:0] idx
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  outWord_q, outWord_d;
  logic [WIDTH-1:0]  outMask_q, outMask_d;

  logic              accept;
  logic              complete;
  logic [SEL_W-1:0]  target;
  logic [WIDTH-1:0]  writeEn;
  logic [WIDTH-1:0]  shadowNext;
  logic [WIDTH-1:0]  maskNext;

  // A pending word blocks new beats unless it is being consumed this same cycle.
  assign din_ready = !rst && ((state_q == COLLECT) || q_ready);
  assign accept    = din_valid && din_ready;
  assign target    = sel_mode ? s : idx_q;
  assign complete  = accept && isCompletion(last, sel_mode, idx_q);

  dec_4to16 u_dec (
    .idx_i    (target),
    .onehot_o (writeEn)
  );

  assign shadowNext = din ? (shadow_q | writeEn) : (shadow_q & ~writeEn);
  assign maskNext   = mask_q | writeEn;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    mask_d    = mask_q;
    outWord_d = outWord_q;
    outMask_d = outMask_q;

    if (accept) begin
      shadow_d = shadowNext;
      mask_d   = maskNext;
      idx_d    = target + SEL_W'(1);
    end

    // A completion beat reloads the output even while the previous word is consumed.
    if (complete) begin
      outWord_d = shadowNext;
      outMask_d = maskNext;
      shadow_d  = '0;
      mask_d    = '0;
      idx_d     = '0;
      state_d   = OUT;
    end else if ((state_q == OUT) && q_ready) begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      outWord_q <= '0;
      outMask_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      outWord_q <= outWord_d;
      outMask_q <= outMask_d;
    end
  end

  assign q       = outWord_q;
  assign q_mask  = outMask_q;
  assign q_valid = (state_q == OUT);
  assign idx     = idx_q;

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Directed self-checking bench for demux_1to16_deser: vector table plus hand-written
// sequences for backpressure, back-to-back completion and mid-word reset.
module tb_demux_1to16_deser;

  logic        clk;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        din_ready;
  logic        sel_mode;
  logic [3:0]  s;
  logic        last;
  logic [15:0] q;
  logic [15:0] q_mask;
  logic        q_valid;
  logic        q_ready;
  logic [3:0]  idx;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct packed {
    logic        dinValid;
    logic        din;
    logic        selMode;
    logic [3:0]  s;
    logic        last;
    logic        qReady;
    logic        expReady;
    logic        expValid;
    logic [15:0] expQ;
    logic [15:0] expMask;
    logic [3:0]  expIdx;
  } vec_t;

  localparam int NUM_VECS = 14;
  vec_t vecs [NUM_VECS];

  demux_1to16_deser dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sel_mode  (sel_mode),
    .s         (s),
    .last      (last),
    .q         (q),
    .q_mask    (q_mask),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .idx       (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Drives one beat, lets the next rising edge take it, then returns 1ns after that edge.
  task automatic applyStimulus(input logic dinBit, input logic selM,
                               input logic [3:0] sIdx, input logic lastBit);
    din_valid = 1'b1;
    din       = dinBit;
    sel_mode  = selM;
    s         = sIdx;
    last      = lastBit;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    last      = 1'b0;
  endtask

  task automatic idleCycle();
    din_valid = 1'b0;
    last      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pattern;

    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    sel_mode  = 1'b0;
    s         = 4'd0;
    last      = 1'b0;
    q_ready   = 1'b1;

    // Addressed word, early-last auto word, then addressed 14/15 followed by auto at 0.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd4};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd10};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd4};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8200, 16'h8208, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd3};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 16'h000B, 16'h000F, 4'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd15};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd9,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC001, 16'hC003, 4'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset din_ready", 16'(din_ready), 16'h0000);
    checkOutput("reset q_valid",   16'(q_valid),   16'h0000);
    checkOutput("reset q",         q,              16'h0000);
    checkOutput("reset q_mask",    q_mask,         16'h0000);
    checkOutput("reset idx",       16'(idx),       16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("post-reset din_ready", 16'(din_ready), 16'h0001);

    // Auto mode, 0xA5C3 LSB-first with q_ready held high.
    pattern = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(pattern[i], 1'b0, 4'd0, 1'b0);
      if (i < 15) begin
        checkOutput($sformatf("auto idx beat %0d", i), 16'(idx), 16'(i + 1));
        checkOutput($sformatf("auto q_valid beat %0d", i), 16'(q_valid), 16'h0000);
      end
    end
    checkOutput("auto q_valid",  16'(q_valid), 16'h0001);
    checkOutput("auto q",        q,            16'hA5C3);
    checkOutput("auto q_mask",   q_mask,       16'hFFFF);
    checkOutput("auto idx wrap", 16'(idx),     16'h0000);
    idleCycle();
    checkOutput("auto q_valid one cycle", 16'(q_valid), 16'h0000);

    // Backpressure: first word 0x1234 completes with q_ready low, then 0xBEEF.
    q_ready = 1'b0;
    pattern = 16'h1234;
    for (int i = 0; i < 16; i++) applyStimulus(pattern[i], 1'b0, 4'd0, 1'b0);
    checkOutput("bp q_valid", 16'(q_valid), 16'h0001);
    checkOutput("bp q",       q,            16'h1234);
    pattern   = 16'hBEEF;
    din_valid = 1'b1;
    din       = pattern[0];
    sel_mode  = 1'b0;
    #1;
    checkOutput("bp din_ready stalled", 16'(din_ready), 16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp hold q %0d", c),       q,            16'h1234);
      checkOutput($sformatf("bp hold q_valid %0d", c), 16'(q_valid), 16'h0001);
      checkOutput($sformatf("bp hold idx %0d", c),     16'(idx),     16'h0000);
    end
    q_ready = 1'b1;
    #1;
    checkOutput("bp din_ready released", 16'(din_ready), 16'h0001);
    for (int i = 0; i < 16; i++) applyStimulus(pattern[i], 1'b0, 4'd0, 1'b0);
    checkOutput("bp second q_valid", 16'(q_valid), 16'h0001);
    checkOutput("bp second q",       q,            16'hBEEF);
    checkOutput("bp second q_mask",  q_mask,       16'hFFFF);
    idleCycle();
    checkOutput("bp consumed", 16'(q_valid), 16'h0000);

    // Vector table: addressed mode, early last, addressed-to-auto pointer handoff.
    for (int i = 0; i < NUM_VECS; i++) begin
      din_valid = vecs[i].dinValid;
      din       = vecs[i].din;
      sel_mode  = vecs[i].selMode;
      s         = vecs[i].s;
      last      = vecs[i].last;
      q_ready   = vecs[i].qReady;
      #1;
      checkOutput($sformatf("vec%0d din_ready", i), 16'(din_ready), 16'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d q_valid", i), 16'(q_valid), 16'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d idx", i),     16'(idx),     16'(vecs[i].expIdx));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d q", i),      q,      vecs[i].expQ);
        checkOutput($sformatf("vec%0d q_mask", i), q_mask, vecs[i].expMask);
      end
    end
    din_valid = 1'b0;
    last      = 1'b0;

    // Back-to-back: a completion beat lands in the same cycle the previous word is taken.
    q_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b1);
    checkOutput("b2b first q_valid", 16'(q_valid), 16'h0001);
    checkOutput("b2b first q",       q,            16'h0020);
    din_valid = 1'b1;
    din       = 1'b1;
    sel_mode  = 1'b1;
    s         = 4'd2;
    last      = 1'b1;
    #1;
    checkOutput("b2b din_ready", 16'(din_ready), 16'h0001);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    last      = 1'b0;
    checkOutput("b2b second q_valid", 16'(q_valid), 16'h0001);
    checkOutput("b2b second q",       q,            16'h0004);
    checkOutput("b2b second q_mask",  q_mask,       16'h0004);
    idleCycle();
    checkOutput("b2b drained", 16'(q_valid), 16'h0000);

    // Reset mid-word after 7 beats discards the partial shadow and mask.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("midword idx", 16'(idx), 16'h0007);
    rst = 1'b1;
    #1;
    checkOutput("midword rst din_ready", 16'(din_ready), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midword rst q_valid", 16'(q_valid), 16'h0000);
    checkOutput("midword rst idx",     16'(idx),     16'h0000);
    applyStimulus(1'b1, 1'b1, 4'd8, 1'b1);
    checkOutput("residue q",      q,      16'h0100);
    checkOutput("residue q_mask", q_mask, 16'h0100);
    idleCycle();

    // Fresh 0xFFFF word, then reset while it is still pending.
    q_ready = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("fresh q_valid", 16'(q_valid), 16'h0001);
    checkOutput("fresh q",       q,            16'hFFFF);
    checkOutput("fresh q_mask",  q_mask,       16'hFFFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("pending rst q_valid", 16'(q_valid), 16'h0000);
    checkOutput("pending rst q",       q,            16'h0000);
    checkOutput("pending rst q_mask",  q_mask,       16'h0000);
    q_ready = 1'b1;
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/demux_1to16_deser.md
# demux_1to16_deser

- Serial-to-parallel 1:16 demultiplexer, the receive-side counterpart of the team's 16:1 bit mux.
- Accepts one data bit per valid/ready beat and steers it into a 16-bit shadow word.
- Steering is by an auto-incrementing pointer or an explicit select.
- Presents the completed word on a valid/ready output port; sits at the far end of any link fed by the time-multiplexed 16:1 mux path.

## Interface
- WIDTH, 16, output word width; fixed at 16 (select is 4 bits).
- SEL_W, 4, select/pointer width, equals log2(WIDTH).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din beat present.
- din_ready  out  1  block can accept a beat.
- sel_mode  in  1  0 = auto (write at pointer), 1 = addressed (write at s); sampled per beat.
- s  in  4  destination bit index when sel_mode=1.
- last  in  1  beat completes the current word (either mode).
- q  out  16  completed word.
- q_mask  out  16  bits of q actually written during that word.
- q_valid  out  1  q/q_mask valid.
- q_ready  in  1  downstream accepts q.
- idx  out  4  current write pointer.

## Operation
- Accepted beat: din_valid && din_ready.
- Target index: `t = sel_mode ? s : idx`.
- On each accepted beat:
  - shadow[t] <= din; mask[t] <= 1.
  - idx <= t+1 mod 16 (wraps 15->0).
- Completion beat: accepted beat with last=1, or sel_mode=0 && idx==15.
  - q <= shadow with bit t replaced by din.
  - q_mask <= mask | onehot(t); q_valid <= 1.
  - shadow, mask, idx all cleared to 0.
- Unwritten bits of q are 0. Rewriting the same index within a word: last write wins.
- Mode may change between beats; the pointer continues from the last target+1.
- FSM, 2 states:
  - COLLECT (q_valid=0): -> OUT on completion beat.
  - OUT (q_valid=1):
    - -> COLLECT on q_ready with no completion beat that cycle.
    - stays OUT on q_ready with a completion beat (back-to-back, new word loaded).
    - stays OUT with q/q_mask held stable while !q_ready.
- din_ready = !rst && (!q_valid || q_ready). The block stalls all beats while an unconsumed word is pending. No beat is ever dropped.
- Reset values: q=0, q_mask=0, q_valid=0, idx=0, shadow=0, mask=0, state=COLLECT; din_ready=0 while rst=1.
- Reset mid-word discards partial shadow and any pending q.

## Timing
- din_ready is combinational from q_valid, q_ready and rst. No other combinational input-to-output path.
- Latency: q_valid rises on the clock edge that accepts the completion beat; it is visible the cycle after.
- Throughput:
  - Auto mode, q_ready held 1: one word per 16 cycles, no bubbles.
  - Addressed mode: 1 to N beats per word.
- idx updates on the same edge as the accepted beat. It reads 0 after a completion beat.
- q, q_mask, q_valid are registered. They change only on a completion beat or when q_ready consumes the word.

## Structure
- Package demux_pkg:
  - WIDTH=16, SEL_W=4 constants.
  - state enum {COLLECT, OUT}.
  - completion-condition helper function.
- Sub-module dec_4to16: 4-bit index to 16-bit one-hot write-enable, used for both the shadow write and the mask update.
- Top holds the shadow, mask, pointer, output register and FSM.

## Test plan
- Auto mode, q_ready=1: 16 beats of pattern 0xA5C3 LSB-first -> q=0xA5C3, q_mask=0xFFFF, q_valid for exactly 1 cycle after beat 16, idx=0.
- Backpressure: q_ready=0 after the first word 0x1234 completes -> din_ready=0, q holds 0x1234. Raise q_ready -> next 16 beats give 0xBEEF with no lost bits.
- Addressed mode:
  - beats (s=3,din=1), (s=9,din=1), (s=3,din=0), (s=15,din=1,last=1) -> q=0x8200, q_mask=0x8208.
- Mixed/early last:
  - auto beats 1,1,0, then last=1 on 4th beat din=1 -> q=0x000B, q_mask=0x000F.
  - 2 addressed beats at s=14,15 (din=1,1), next auto beat lands at idx=0.
- Back-to-back: a completion beat in the same cycle q_ready consumes the previous word -> q_valid stays 1 and q updates to the new word on the next edge.
- Reset mid-word after 7 beats -> q_valid=0, idx=0. Then 16 fresh beats of 0xFFFF -> q=0xFFFF with no residue.
